// File: rtl/spi_alu_node_if.sv
// SPI pin bundle for the ALU node: the master drives SCLK/MOSI/SS and the node returns MISO.
interface spi_alu_node_if;
  logic SCLK;
  logic MOSI;
  logic SS;
  logic MISO;

  modport master (output SCLK, output MOSI, output SS, input MISO);
  modport slave  (input SCLK, input MOSI, input SS, output MISO);
endinterface

// File: rtl/spi_alu_node.sv
// SPI mode-0 controlled ALU node: one frame carries A, B and the opcode, the node answers with
// the previous result and flags, and a PWM LED shows the committed result as a duty cycle.
module spi_alu_node #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_alu_node_if.slave  spi,
  output logic [W-1:0]   result,
  output logic           N,
  output logic           Z,
  output logic           C,
  output logic           V,
  output logic           frame_valid,
  output logic           frame_err,
  output logic           led
);

  localparam int F  = 2*W + 2;
  localparam int CW = $clog2(F + 2);
  localparam int SW = $clog2(SYNC_STAGES + 1) + 1;

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] RECV      = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [F-1:0]  rx_q, rx_d;
  logic [F-1:0]  tx_q, tx_d;
  logic          miso_q, miso_d;

  logic [W-1:0]  result_q, result_d;
  logic          n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic          led_q, led_d;

  logic          sclk_s, mosi_s, ss_s;
  logic          sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [F-1:0]  tx_load;

  logic [W-1:0]  op_a, op_b;
  logic [1:0]    op_sel;
  logic [W:0]    sum, diff;
  logic [W-1:0]  alu_r;
  logic          alu_c, alu_v;

  always_comb begin
    sclk_sync_d = (sclk_sync_q << 1) | SYNC_STAGES'(spi.SCLK);
    mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(spi.MOSI);
    ss_sync_d   = (ss_sync_q << 1)   | SYNC_STAGES'(spi.SS);
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    ss_fall     = ~ss_s & ss_prev_q;
    ss_rise     = ss_s & ~ss_prev_q;
  end

  // Reply word: previous result and flags, left-aligned in the frame, zero-padded.
  always_comb begin
    tx_load = F'({result_q, n_q, z_q, c_q, v_q}) << (F - W - 4);
  end

  always_comb begin
    op_a   = rx_q[F-1 -: W];
    op_b   = rx_q[W+1 -: W];
    op_sel = rx_q[1:0];
    sum    = {1'b0, op_a} + {1'b0, op_b};
    diff   = {1'b0, op_a} - {1'b0, op_b};
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op_sel)
      2'b00: begin
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
      end
      2'b01: begin
        alu_r = diff[W-1:0];
        alu_c = ~diff[W];
        alu_v = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
      end
      2'b10:   alu_r = op_a & op_b;
      default: alu_r = op_a | op_b;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    result_d      = result_q;
    n_d           = n_q;
    z_d           = z_q;
    c_d           = c_q;
    v_d           = v_q;
    frame_valid_d = 1'b0;
    frame_err_d   = frame_err_q;
    case (state_q)
      // The synchroniser resets to SS=1, so only trust SS high once real pin samples have arrived.
      WAIT_IDLE: begin
        if (ss_s) begin
          if (settle_q == SW'(SYNC_STAGES)) state_d = IDLE;
          else                               settle_d = settle_q + 1'b1;
        end else begin
          settle_d = '0;
        end
      end
      IDLE: begin
        if (ss_fall) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          tx_d      = tx_load;
        end
      end
      RECV: begin
        if (ss_rise) begin
          state_d = COMMIT;
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[F-2:0], mosi_s};
            if (bit_cnt_q != CW'(F + 1)) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (sclk_fall) tx_d = tx_q << 1;
        end
      end
      default: begin
        state_d = IDLE;
        if (bit_cnt_q == CW'(F)) begin
          result_d      = alu_r;
          n_d           = alu_r[W-1];
          z_d           = (alu_r == '0);
          c_d           = alu_c;
          v_d           = alu_v;
          frame_valid_d = 1'b1;
          frame_err_d   = 1'b0;
        end else begin
          frame_err_d   = 1'b1;
        end
      end
    endcase
    miso_d = (state_d == RECV) ? tx_d[F-1] : 1'b0;
  end

  // Free-running PWM; a new result simply changes the compare threshold.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_d     = (pwm_cnt_q < result_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      ss_sync_q     <= '1;
      sclk_prev_q   <= 1'b0;
      ss_prev_q     <= 1'b1;
      state_q       <= WAIT_IDLE;
      settle_q      <= '0;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      miso_q        <= 1'b0;
      result_q      <= '0;
      n_q           <= 1'b0;
      z_q           <= 1'b0;
      c_q           <= 1'b0;
      v_q           <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      pwm_cnt_q     <= '0;
      led_q         <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_sync_q     <= ss_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      ss_prev_q     <= ss_prev_d;
      state_q       <= state_d;
      settle_q      <= settle_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      miso_q        <= miso_d;
      result_q      <= result_d;
      n_q           <= n_d;
      z_q           <= z_d;
      c_q           <= c_d;
      v_q           <= v_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_q         <= led_d;
    end
  end

  assign spi.MISO    = miso_q;
  assign result      = result_q;
  assign N           = n_q;
  assign Z           = z_q;
  assign C           = c_q;
  assign V           = v_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign led         = led_q;

endmodule

// File: tb/tb_spi_alu_node.sv
// Bench for spi_alu_node: table vectors, random frames against an arithmetic model,
// plus hand sequences for bad frame lengths, reset mid-frame and PWM duty.
module tb_spi_alu_node;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int F    = 2*W + 2;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_alu_node_if bus();
  logic [W-1:0] result;
  logic n, z, c, v, frame_valid, frame_err, led;

  spi_alu_node #(.W(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi(bus.slave), .result(result),
    .N(n), .Z(z), .C(c), .V(v),
    .frame_valid(frame_valid), .frame_err(frame_err), .led(led)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic [W-1:0] r;
    logic         n, z, c, v;
  } vec_t;

  vec_t vecs[8];
  int total = 0;
  int bad = 0;
  logic [W+3:0] prev_out;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: signed/unsigned ranges checked with plain integers.
  function automatic logic [W+3:0] alu_model(input int a, input int b, input int sel);
    int m = 1 << W;
    int h = m / 2;
    int sa = (a >= h) ? a - m : a;
    int sb = (b >= h) ? b - m : b;
    int r = 0;
    int sr;
    logic cc = 1'b0;
    logic vv = 1'b0;
    logic [W-1:0] rr;
    case (sel)
      0: begin r = (a + b) % m; cc = (a + b) >= m; sr = sa + sb; vv = (sr >= h) || (sr < -h); end
      1: begin r = (a - b + m) % m; cc = (a >= b); sr = sa - sb; vv = (sr >= h) || (sr < -h); end
      2: r = a & b;
      default: r = a | b;
    endcase
    rr = r[W-1:0];
    return {rr, (r >= h), (r == 0), cc, vv};
  endfunction

  task shiftFrame(input logic [31:0] bits, input int nbits, output logic [31:0] miso_bits);
    miso_bits = '0;
    bus.SS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.MOSI = bits[i];
      repeat (HALF) @(negedge clk);
      miso_bits = {miso_bits[30:0], bus.MISO};
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task endFrame(output int first_k, output int pulses);
    bus.SS = 1'b1;
    first_k = -1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_valid) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  task applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel,
                     input logic [W+3:0] exp, input string tag);
    logic [31:0] bits, miso, exp_miso;
    int k, p;
    bits = (32'(a) << (W + 2)) | (32'(b) << 2) | 32'(sel);
    exp_miso = 32'(prev_out) << (F - W - 4);
    shiftFrame(bits, F, miso);
    checkOutput({tag, " miso"}, miso, exp_miso);
    endFrame(k, p);
    checkOutput({tag, " latency"}, k, SYNC + 2);
    checkOutput({tag, " pulses"}, p, 1);
    checkOutput({tag, " result"}, 32'(result), 32'(exp[W+3:4]));
    checkOutput({tag, " flags"}, {n, z, c, v}, 32'(exp[3:0]));
    checkOutput({tag, " frame_err"}, 32'(frame_err), 0);
    prev_out = exp;
  endtask

  task badFrame(input int nbits, input string tag);
    logic [31:0] miso;
    int k, p;
    shiftFrame(32'h2A5, nbits, miso);
    endFrame(k, p);
    checkOutput({tag, " pulses"}, p, 0);
    checkOutput({tag, " frame_err"}, 32'(frame_err), 1);
    checkOutput({tag, " result"}, 32'(result), 32'(prev_out[W+3:4]));
  endtask

  task countLed(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (led) highs++;
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rs;
    int highs;

    vecs[0] = '{4'd7,  4'd9,  2'b00, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{4'd3,  4'd5,  2'b01, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'd7,  4'd1,  2'b00, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'd12, 4'd10, 2'b10, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'd8,  4'd8,  2'b00, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{4'd9,  4'd9,  2'b01, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'd5,  4'd3,  2'b11, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'd2,  4'd3,  2'b00, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.SS = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    prev_out = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset result", 32'(result), 0);
    checkOutput("reset flags", {n, z, c, v}, 0);
    checkOutput("reset valid_err_led_miso", {frame_valid, frame_err, led, bus.MISO}, 0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sel,
                    {vecs[i].r, vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v},
                    $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rs = 2'($urandom_range(0, 3));
      applyStimulus(ra, rb, rs, alu_model(ra, rb, rs), $sformatf("rand%0d", i));
    end

    badFrame(9, "short9");
    badFrame(11, "long11");
    applyStimulus(4'd6, 4'd3, 2'b01, alu_model(6, 3, 1), "after_bad");

    // Reset after five bits with SS still low; the tail of that frame must be ignored.
    bus.SS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < F; i++) begin
      bus.MOSI = i[0];
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
      if (i == 4) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst result", 32'(result), 0);
        checkOutput("midrst flags", {n, z, c, v}, 0);
        checkOutput("midrst valid_err_led_miso", {frame_valid, frame_err, led, bus.MISO}, 0);
        prev_out = '0;
      end
    end
    repeat (HALF) @(negedge clk);
    begin
      int k, p;
      endFrame(k, p);
      checkOutput("midrst tail pulses", p, 0);
      checkOutput("midrst tail frame_err", 32'(frame_err), 0);
      checkOutput("midrst tail result", 32'(result), 0);
    end
    applyStimulus(4'd2, 4'd3, 2'b00, alu_model(2, 3, 0), "post_rst");

    applyStimulus(4'd4, 4'd0, 2'b11, alu_model(4, 0, 3), "pwm4");
    countLed(16, highs);
    checkOutput("pwm4 duty16", highs, 4);
    countLed(32, highs);
    checkOutput("pwm4 duty32", highs, 8);

    applyStimulus(4'd15, 4'd0, 2'b11, alu_model(15, 0, 3), "pwm15");
    countLed(32, highs);
    checkOutput("pwm15 duty32", highs, 30);

    applyStimulus(4'd0, 4'd0, 2'b10, alu_model(0, 0, 2), "pwm0");
    countLed(32, highs);
    checkOutput("pwm0 duty32", highs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
